apb_crc_byte_feeder: RTL and testbench
======================================

# apb_crc_byte_feeder

Upstream stage of the APB CRC path. Accepts 32-bit words with a byte count and end-of-message flag over a valid/ready handshake and buffers them in a small FIFO. Serializes them into the 8-bit, single-cycle-valid byte stream consumed by the CRC engine at one byte per clock. Signals message completion, so software can write whole words instead of single bytes.

## Interface
- FIFO_DEPTH, 4, word FIFO entries; power of two, >= 2
- MSB_FIRST, 1, 1: byte [31:24] issued first; 0: byte [7:0] issued first
- clk  input  1  clock, all logic on rising edge
- rstn  input  1  reset, asynchronous, active-low
- word_data  input  32  packed message bytes
- word_bytes  input  2  number of valid bytes minus 1 (0 = 1 byte, 3 = 4 bytes)
- word_last  input  1  word ends a message
- word_valid  input  1  word offered
- word_ready  output  1  word accepted on edge where valid & ready
- abort  input  1  synchronous flush of FIFO and serializer
- byte_data  output  8  serialized byte to CRC engine
- byte_valid  output  1  byte_data valid this cycle; no backpressure
- msg_done  output  1  one-cycle pulse after final byte of a message
- busy  output  1  FIFO non-empty or serializer holding bytes
- fifo_level  output  $clog2(FIFO_DEPTH)+1  words currently in FIFO

## Operation
- FIFO: stores {data, bytes, last}; word_ready = (fifo_level != FIFO_DEPTH) & !abort, combinational from registered level. No pass-through: full FIFO deasserts ready even if a pop occurs that cycle. Push and pop in the same cycle leave the level unchanged.
- Valid bytes of a short word:
  - MSB_FIRST=1: most significant bytes, issued from [31:24] downward.
  - MSB_FIRST=0: least significant bytes, issued from [7:0] upward.
  - Unused bytes are ignored.
- Serializer FSM:
  - IDLE: no bytes held. If FIFO non-empty, pop and load the shift register and remaining-count (word_bytes), then go to SHIFT.
  - SHIFT: each cycle present the current byte with byte_valid=1 and decrement the remaining-count.
  - On the final byte: if FIFO non-empty, pop and reload in the same edge and stay in SHIFT (gapless); else return to IDLE.
- msg_done: registered; asserted the cycle after the final byte of a word with last=1 is presented; exactly one pulse per message.
- busy = (fifo_level != 0) | (state == SHIFT).
- abort (highest priority):
  - On the edge it is sampled, the FIFO empties, the FSM goes to IDLE and pending msg_done is cancelled.
  - byte_valid=0 from the next cycle.
  - A word offered during the abort cycle is not accepted.

## Timing
- Reset values: byte_valid 0, byte_data 8'h00, msg_done 0, busy 0, fifo_level 0, FSM IDLE; word_ready 1 once rstn deasserted (FIFO empty).
- Reset asserted mid-message discards all state immediately (async); no msg_done.
- Latency: word accepted at edge E0 -> popped/loaded at E1 -> first byte_valid in cycle after E1. A 4-byte word occupies 4 consecutive byte_valid cycles.
- Throughput: 1 byte/cycle sustained with back-to-back words; no idle cycle between words while the FIFO is non-empty.
- Input may outrun output: at 1 word/cycle the FIFO fills after FIFO_DEPTH accepts plus serializer drain; ready stays low until a pop frees an entry (ready high the cycle after the pop edge).
- byte_data holds its last value when byte_valid=0; consumers must qualify with byte_valid.
- fifo_level updates on the edge of push/pop; never exceeds FIFO_DEPTH, never underflows.

## Test plan
- Single word 32'h31323334, word_bytes=3, last=1, MSB_FIRST=1 -> bytes 31,32,33,34 on 4 consecutive cycles starting 2 edges after accept; msg_done pulse in the following cycle; busy drops with it.
- Short words: 32'hAABBCCDD bytes=0 then 32'h11223344 bytes=1 last=1 -> bytes AA, 11, 22 contiguous; single msg_done. With MSB_FIRST=0 -> DD, 44, 33.
- Backpressure: hold word_valid high with 8 distinct words, FIFO_DEPTH=4 -> ready drops after FIFO fills; all 32 bytes emitted in order with no gaps or duplicates; fifo_level peaks at 4.
- Two messages back-to-back (last on words 1 and 3) -> two msg_done pulses, each one cycle after its final byte; byte stream continuous.
- abort asserted during 2nd byte of a 3-word queue -> byte_valid low next cycle, fifo_level 0, no msg_done; next word after abort serializes normally.
- rstn pulsed low mid-SHIFT -> all outputs at reset values asynchronously; after release word_ready=1 and a new word serializes correctly.

Source files
------------

// File: rtl/apb_crc_byte_feeder.sv
// Word-to-byte feeder for the CRC engine: a small word FIFO followed by
// a shift-register serializer emitting one byte per clock.
module apb_crc_byte_feeder #(
    parameter int FIFO_DEPTH = 4,
    parameter bit MSB_FIRST  = 1'b1
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic [31:0]                 word_data,
    input  logic [1:0]                  word_bytes,
    input  logic                        word_last,
    input  logic                        word_valid,
    output logic                        word_ready,
    input  logic                        abort,
    output logic [7:0]                  byte_data,
    output logic                        byte_valid,
    output logic                        msg_done,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL = LW'(FIFO_DEPTH);

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  bytes;
        logic        last;
    } entry_t;

    typedef enum logic {IDLE, SHIFT} state_e;

    entry_t        mem_q [FIFO_DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [LW-1:0] level_q, level_d;
    state_e        state_q, state_d;
    logic [31:0]   sh_q, sh_d;
    logic [1:0]    cnt_q, cnt_d;
    logic          last_q, last_d;
    logic          done_q, done_d;
    logic          push, pop, fifo_empty;
    entry_t        head;

    assign fifo_empty = (level_q == '0);
    assign word_ready = (level_q != FULL) && !abort;
    assign push       = word_valid && word_ready;
    assign head       = mem_q[rptr_q];

    assign byte_data  = MSB_FIRST ? sh_q[31:24] : sh_q[7:0];
    assign byte_valid = (state_q == SHIFT);
    assign msg_done   = done_q;
    assign busy       = !fifo_empty || (state_q == SHIFT);
    assign fifo_level = level_q;

    // Storage is not reset; validity is tracked by the pointers and level.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= {word_data, word_bytes, word_last};
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else if (abort) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop)  rptr_q <= rptr_q + 1'b1;
            level_q <= level_d;
        end
    end

    always_comb begin
        level_d = level_q + LW'(push) - LW'(pop);
    end

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        done_d  = 1'b0;
        pop     = 1'b0;
        if (!abort) begin
            unique case (state_q)
                IDLE: begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        state_d = SHIFT;
                        sh_d    = head.data;
                        cnt_d   = head.bytes;
                        last_d  = head.last;
                    end
                end
                SHIFT: begin
                    if (cnt_q == 2'd0) begin
                        done_d = last_q;
                        // Reload on the final byte keeps the stream gapless.
                        if (!fifo_empty) begin
                            pop    = 1'b1;
                            sh_d   = head.data;
                            cnt_d  = head.bytes;
                            last_d = head.last;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q - 2'd1;
                        sh_d  = MSB_FIRST ? {sh_q[23:0], 8'h00}
                                          : {8'h00, sh_q[31:8]};
                    end
                end
                default: state_d = IDLE;
            endcase
        end else begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            sh_q    <= '0;
            cnt_q   <= '0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_apb_crc_byte_feeder.sv
// Bench for apb_crc_byte_feeder: MSB-first and LSB-first instances share
// stimulus; a byte-queue model predicts every output each cycle.
module tb_apb_crc_byte_feeder;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [31:0] word_data = '0;
    logic [1:0]  word_bytes = '0;
    logic        word_last = 1'b0;
    logic        word_valid = 1'b0;
    logic        abort = 1'b0;

    logic        rdy_m, bv_m, md_m, busy_m;
    logic [7:0]  bd_m;
    logic [2:0]  lvl_m;
    logic        rdy_l, bv_l, md_l, busy_l;
    logic [7:0]  bd_l;
    logic [2:0]  lvl_l;

    apb_crc_byte_feeder #(.FIFO_DEPTH(DEPTH), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rstn(rstn),
        .word_data(word_data), .word_bytes(word_bytes),
        .word_last(word_last), .word_valid(word_valid),
        .word_ready(rdy_m), .abort(abort),
        .byte_data(bd_m), .byte_valid(bv_m), .msg_done(md_m),
        .busy(busy_m), .fifo_level(lvl_m)
    );

    apb_crc_byte_feeder #(.FIFO_DEPTH(DEPTH), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rstn(rstn),
        .word_data(word_data), .word_bytes(word_bytes),
        .word_last(word_last), .word_valid(word_valid),
        .word_ready(rdy_l), .abort(abort),
        .byte_data(bd_l), .byte_valid(bv_l), .msg_done(md_l),
        .busy(busy_l), .fifo_level(lvl_l)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] bm;
        logic [7:0] bl;
        bit         first;
        bit         fin;
        int         acc;
    } mb_t;

    mb_t        q[$];
    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    int         lvl_exp = 0;
    int         peak = 0;
    bit         done_exp = 0;
    bit         done_next = 0;
    bit         last_acc = 0;
    logic [7:0] hold_m = 8'h00;
    logic [7:0] hold_l = 8'h00;

    task automatic chk(input string tag, input logic [31:0] o,
                       input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    task automatic model_push(input logic [31:0] d, input logic [1:0] b,
                              input bit l);
        int n;
        mb_t e;
        n = int'(b) + 1;
        for (int i = 0; i < n; i++) begin
            e.bm    = d[31-8*i -: 8];
            e.bl    = d[8*i +: 8];
            e.first = (i == 0);
            e.fin   = l && (i == n - 1);
            e.acc   = cyc;
            q.push_back(e);
        end
    endtask

    // A word accepted at edge N is loaded at N+1 and shown after it.
    task automatic sample();
        bit ev;
        int firsts;
        int lvl;
        firsts = 0;
        ev = (q.size() > 0) && (q[0].acc <= cyc - 1);
        foreach (q[i]) if (q[i].first) firsts++;
        lvl = firsts - ((ev && q[0].first) ? 1 : 0);
        chk("valid_m", bv_m, ev);
        chk("valid_l", bv_l, ev);
        if (ev) begin
            chk("data_m", bd_m, q[0].bm);
            chk("data_l", bd_l, q[0].bl);
            hold_m = q[0].bm;
            hold_l = q[0].bl;
        end else begin
            chk("hold_m", bd_m, hold_m);
            chk("hold_l", bd_l, hold_l);
        end
        chk("done_m", md_m, done_exp);
        chk("done_l", md_l, done_exp);
        chk("busy_m", busy_m, q.size() > 0);
        chk("busy_l", busy_l, q.size() > 0);
        chk("level_m", lvl_m, lvl);
        chk("level_l", lvl_l, lvl);
        chk("ready_m", rdy_m, (lvl != DEPTH) && !abort);
        chk("ready_l", rdy_l, (lvl != DEPTH) && !abort);
        if (int'(lvl_m) > peak) peak = int'(lvl_m);
        done_next = ev && q[0].fin;
        lvl_exp = lvl;
        if (ev) void'(q.pop_front());
    endtask

    task automatic step(input bit v, input logic [31:0] d,
                        input logic [1:0] b, input bit l, input bit ab);
        bit acc;
        word_valid = v;
        word_data  = d;
        word_bytes = b;
        word_last  = l;
        abort      = ab;
        acc = v && !ab && (lvl_exp != DEPTH);
        last_acc = acc;
        @(posedge clk);
        cyc++;
        if (ab) begin
            q.delete();
            done_exp = 0;
        end else begin
            done_exp = done_next;
        end
        if (acc) model_push(d, b, l);
        #1;
        sample();
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 32'h0, 2'd0, 1'b0, 1'b0);
    endtask

    task automatic send(input logic [31:0] d, input logic [1:0] b,
                        input bit l);
        for (int k = 0; k < 50; k++) begin
            step(1'b1, d, b, l, 1'b0);
            if (last_acc) break;
        end
        chk("send_accepted", last_acc, 1'b1);
        word_valid = 1'b0;
    endtask

    task automatic pulse_reset();
        word_valid = 1'b0;
        abort = 1'b0;
        #2 rstn = 1'b0;
        #1;
        chk("rst_valid", bv_m, 1'b0);
        chk("rst_data_m", bd_m, 8'h00);
        chk("rst_data_l", bd_l, 8'h00);
        chk("rst_done", md_m, 1'b0);
        chk("rst_busy", busy_m, 1'b0);
        chk("rst_level", lvl_m, 0);
        q.delete();
        done_exp = 0;
        done_next = 0;
        lvl_exp = 0;
        hold_m = 8'h00;
        hold_l = 8'h00;
        #1 rstn = 1'b1;
        #1;
        chk("rst_ready", rdy_m, 1'b1);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("init_valid", bv_m, 1'b0);
        chk("init_data", bd_m, 8'h00);
        chk("init_done", md_m, 1'b0);
        chk("init_busy", busy_m, 1'b0);
        chk("init_level", lvl_m, 0);
        @(negedge clk);
        rstn = 1'b1;
        #1;
        chk("init_ready", rdy_m, 1'b1);

        send(32'h31323334, 2'd3, 1'b1);
        idle(8);

        send(32'hAABBCCDD, 2'd0, 1'b0);
        send(32'h11223344, 2'd1, 1'b1);
        idle(6);

        peak = 0;
        for (int i = 0; i < 8; i++) begin
            send(32'h01020304 + 32'h10101010 * i, 2'd3, i == 7);
        end
        idle(40);
        chk("peak_level", peak, DEPTH);

        send(32'hC0C1C2C3, 2'd3, 1'b1);
        send(32'hD0D1D2D3, 2'd2, 1'b0);
        send(32'hE0E1E2E3, 2'd1, 1'b1);
        idle(12);

        send(32'hA1A2A3A4, 2'd2, 1'b1);
        send(32'hB1B2B3B4, 2'd2, 1'b1);
        send(32'hC1C2C3C4, 2'd2, 1'b1);
        step(1'b1, 32'hDEADBEEF, 2'd3, 1'b1, 1'b1);
        chk("abort_valid", bv_m, 1'b0);
        chk("abort_level", lvl_m, 0);
        idle(3);
        send(32'h5A5B5C5D, 2'd3, 1'b1);
        idle(8);

        send(32'h61626364, 2'd3, 1'b1);
        idle(2);
        pulse_reset();
        idle(4);
        send(32'h71727374, 2'd3, 1'b1);
        idle(8);

        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 9) < 7, $urandom, 2'($urandom),
                 $urandom_range(0, 2) == 0, $urandom_range(0, 49) == 0);
        end
        idle(40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
